// File: rtl/mcu_sched_if.sv
// Block-command channel between mcu_sched and the Huffman decoder,
// plus the IDCT completion strobe that returns credit to the scheduler.
interface mcu_sched_if #(
  parameter int CH = 3
);
  localparam int CHW = $clog2(CH + 1);

  logic           cmd_valid;
  logic           cmd_ready;
  logic [CHW-1:0] cmd_ch;
  logic           cmd_dc_rst;
  logic           blk_done;

  modport master (
    output cmd_valid, cmd_ch, cmd_dc_rst,
    input  cmd_ready, blk_done
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_dc_rst,
    output cmd_ready, blk_done
  );
endinterface

// File: rtl/mcu_sched.sv
// JPEG scan scheduler: issues one command per 8x8 block, MCU by MCU, with a
// credit limit on blocks in flight and a full drain at each restart boundary.
module mcu_sched #(
  parameter int CH       = 3,
  parameter int BLOCKS_Y = 1,
  parameter int MAX_OUT  = 2,
  parameter int MCU_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MCU_W-1:0] num_mcus,
  input  logic [15:0]      restart_int,
  mcu_sched_if.master      cmd,
  output logic             rst_marker,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int CHW = $clog2(CH + 1);
  localparam int BPM = BLOCKS_Y + CH - 1;
  localparam int BW  = (BPM > 1) ? $clog2(BPM) : 1;
  localparam int OW  = $clog2(MAX_OUT + 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BPM - 1);
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t           state_q, state_d;
  logic [MCU_W-1:0] nmcu_q, nmcu_d, mcu_cnt_q, mcu_cnt_d;
  logic [15:0]      rint_q, rint_d, rint_cnt_q, rint_cnt_d;
  logic [BW-1:0]    blk_idx_q, blk_idx_d;
  logic [OW-1:0]    out_cnt_q, out_cnt_d;
  logic [CH-1:0]    dc_arm_q, dc_arm_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [CHW-1:0]   cmd_ch_q, cmd_ch_d;
  logic             cmd_dc_rst_q, cmd_dc_rst_d;
  logic             rst_marker_q, rst_marker_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             hs, dec;

  function automatic logic [CHW-1:0] ch_of(input logic [BW-1:0] idx);
    if (int'(idx) < BLOCKS_Y) return '0;
    return CHW'(int'(idx) - BLOCKS_Y + 1);
  endfunction

  always_comb begin
    hs  = cmd_valid_q & cmd.cmd_ready;
    dec = cmd.blk_done && (out_cnt_q != '0);

    out_cnt_d = out_cnt_q;
    if (hs && !dec)      out_cnt_d = out_cnt_q + OW'(1);
    else if (!hs && dec) out_cnt_d = out_cnt_q - OW'(1);
    err_d = err_q | (cmd.blk_done && (out_cnt_q == '0));

    state_d      = state_q;
    nmcu_d       = nmcu_q;
    rint_d       = rint_q;
    mcu_cnt_d    = mcu_cnt_q;
    rint_cnt_d   = rint_cnt_q;
    blk_idx_d    = blk_idx_q;
    dc_arm_d     = dc_arm_q;
    busy_d       = busy_q;
    rst_marker_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          nmcu_d     = num_mcus;
          rint_d     = restart_int;
          mcu_cnt_d  = '0;
          rint_cnt_d = '0;
          blk_idx_d  = '0;
          dc_arm_d   = '1;
          busy_d     = 1'b1;
          state_d    = (num_mcus == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          for (int unsigned c = 0; c < CH; c++)
            if (ch_of(blk_idx_q) == CHW'(c)) dc_arm_d[c] = 1'b0;
          if (blk_idx_q == BLK_LAST) begin
            blk_idx_d  = '0;
            mcu_cnt_d  = mcu_cnt_q + MCU_W'(1);
            rint_cnt_d = rint_cnt_q + 16'd1;
            if (mcu_cnt_q + MCU_W'(1) == nmcu_q)
              state_d = FIN;
            else if ((rint_q != '0) && (rint_cnt_q + 16'd1 == rint_q))
              state_d = DRAIN;
          end else begin
            blk_idx_d = blk_idx_q + BW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_cnt_d == '0) begin
          rst_marker_d = 1'b1;
          rint_cnt_d   = '0;
          dc_arm_d     = '1;
          state_d      = ISSUE;
        end
      end
      FIN: begin
        if (out_cnt_d == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hold off the first command after a drain so the marker strictly precedes it.
    cmd_valid_d  = (state_d == ISSUE) && (out_cnt_d < OUT_MAX) && !rst_marker_d;
    cmd_ch_d     = ch_of(blk_idx_d);
    cmd_dc_rst_d = 1'b0;
    for (int unsigned c = 0; c < CH; c++)
      if ((state_d == ISSUE) && (ch_of(blk_idx_d) == CHW'(c))) cmd_dc_rst_d = dc_arm_d[c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      nmcu_q       <= '0;
      rint_q       <= '0;
      mcu_cnt_q    <= '0;
      rint_cnt_q   <= '0;
      blk_idx_q    <= '0;
      out_cnt_q    <= '0;
      dc_arm_q     <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_ch_q     <= '0;
      cmd_dc_rst_q <= 1'b0;
      rst_marker_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      nmcu_q       <= nmcu_d;
      rint_q       <= rint_d;
      mcu_cnt_q    <= mcu_cnt_d;
      rint_cnt_q   <= rint_cnt_d;
      blk_idx_q    <= blk_idx_d;
      out_cnt_q    <= out_cnt_d;
      dc_arm_q     <= dc_arm_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_ch_q     <= cmd_ch_d;
      cmd_dc_rst_q <= cmd_dc_rst_d;
      rst_marker_q <= rst_marker_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign cmd.cmd_valid  = cmd_valid_q;
  assign cmd.cmd_ch     = cmd_ch_q;
  assign cmd.cmd_dc_rst = cmd_dc_rst_q;
  assign rst_marker     = rst_marker_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
endmodule

// File: tb/tb_mcu_sched.sv
// Directed bench for mcu_sched: a 4:4:4 instance and a 4:2:0-style instance,
// expected commands queued at start and compared at each handshake.
module tb_mcu_sched;
  localparam int CH      = 3;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st = 1'b0, rdy = 1'b0, bd = 1'b0, sel = 1'b0;
  logic [15:0] nm = '0, ri = '0;
  logic        mk1, busy1, done1, err1, mk4, busy4, done4, err4;

  mcu_sched_if #(.CH(CH)) if1 ();
  mcu_sched_if #(.CH(CH)) if4 ();

  assign if1.cmd_ready = rdy & ~sel;
  assign if1.blk_done  = bd  & ~sel;
  assign if4.cmd_ready = rdy & sel;
  assign if4.blk_done  = bd  & sel;

  mcu_sched #(.CH(CH), .BLOCKS_Y(1), .MAX_OUT(MAX_OUT), .MCU_W(16)) dut (
    .clk(clk), .rst(rst), .start(st & ~sel), .num_mcus(nm), .restart_int(ri),
    .cmd(if1), .rst_marker(mk1), .busy(busy1), .done(done1), .err(err1)
  );

  mcu_sched #(.CH(CH), .BLOCKS_Y(4), .MAX_OUT(MAX_OUT), .MCU_W(16)) dut4 (
    .clk(clk), .rst(rst), .start(st & sel), .num_mcus(nm), .restart_int(ri),
    .cmd(if4), .rst_marker(mk4), .busy(busy4), .done(done4), .err(err4)
  );

  logic       o_valid, o_dc, o_mk, o_busy, o_done, o_err;
  logic [1:0] o_ch;
  assign o_valid = sel ? if4.cmd_valid  : if1.cmd_valid;
  assign o_ch    = sel ? if4.cmd_ch     : if1.cmd_ch;
  assign o_dc    = sel ? if4.cmd_dc_rst : if1.cmd_dc_rst;
  assign o_mk    = sel ? mk4   : mk1;
  assign o_busy  = sel ? busy4 : busy1;
  assign o_done  = sel ? done4 : done1;
  assign o_err   = sel ? err4  : err1;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, mo = 0, issued = 0, total = 0, bpm = 3, nmcu_m = 0, rint_m = 0;
  int lat = 3, mode = 0, n_mk = 0, n_dn = 0;
  bit scanning = 0, draining = 0, prev_fin = 0, prev_stall = 0, err_m = 0;
  logic [1:0] prev_ch = '0;
  logic       prev_dc = 1'b0;
  int sb_q[$];
  int due_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance to next negedge.
  task automatic tick();
    logic v, dc, mk, dn;
    logic [1:0] ch;
    bit exp_v, exp_mk, exp_dn, fin_now, h, b;
    int e;
    v = o_valid; ch = o_ch; dc = o_dc; mk = o_mk; dn = o_done;
    fin_now = scanning && (issued == total);
    exp_mk  = draining && (mo == 0);
    exp_dn  = fin_now && prev_fin && (mo == 0);
    exp_v   = scanning && !draining && (issued < total) && (mo < MAX_OUT);
    chk("cmd_valid", v, exp_v);
    chk("rst_marker", mk, exp_mk);
    chk("done", dn, exp_dn);
    chk("busy", o_busy, scanning && !exp_dn);
    chk("err", o_err, err_m);
    if (prev_stall) begin
      chk("stall_ch", ch, prev_ch);
      chk("stall_dc", dc, prev_dc);
    end
    if (mk) begin
      chk("marker_at_mcu_edge", issued % bpm, 0);
      n_mk++;
    end
    if (dn) n_dn++;

    rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    h = v && rdy;
    b = (due_q.size() > 0) && (due_q[0] <= cyc);
    if (b) void'(due_q.pop_front());
    bd = b;
    prev_fin = fin_now;
    if (h) begin
      if (sb_q.size() == 0) chk("extra_cmd", sb_q.size(), 1);
      else begin
        e = sb_q.pop_front();
        chk("cmd_ch", ch, e & 3);
        chk("cmd_dc_rst", dc, e >> 2);
      end
      issued++;
      due_q.push_back(cyc + lat);
      if ((issued % bpm == 0) && (rint_m != 0) && ((issued / bpm) % rint_m == 0) &&
          (issued / bpm < nmcu_m))
        draining = 1;
    end
    if (b && mo == 0) err_m = 1;
    mo = mo + (h ? 1 : 0) - ((b && mo > 0) ? 1 : 0);
    prev_stall = v && !rdy;
    prev_ch = ch;
    prev_dc = dc;
    if (mk) draining = 0;
    if (dn) scanning = 0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_scan(input bit s, input int n, input int r, input int md, input int lt);
    int by, ch, dc;
    sel = s; by = s ? 4 : 1; bpm = by + CH - 1;
    nmcu_m = n; rint_m = r; total = n * bpm; issued = 0;
    mode = md; lat = lt; mo = 0; draining = 0; prev_fin = 0; prev_stall = 0;
    n_mk = 0; n_dn = 0;
    for (int m = 0; m < n; m++)
      for (int b = 0; b < bpm; b++) begin
        ch = (b < by) ? 0 : b - by + 1;
        dc = ((b == 0 || b >= by) && (m == 0 || (r != 0 && m % r == 0))) ? 1 : 0;
        sb_q.push_back(ch | (dc << 2));
      end
    nm = 16'(n); ri = 16'(r); st = 1'b1;
    tick();
    st = 1'b0;
    scanning = 1;
  endtask

  task automatic finish_scan();
    for (int k = 0; k < 2000 && scanning; k++) tick();
    if (scanning) chk("scan_timeout", scanning, 0);
    chk("sb_left", sb_q.size(), 0);
    chk("handshakes", issued, total);
    chk("done_pulses", n_dn, 1);
    chk("markers", n_mk, (rint_m == 0 || nmcu_m == 0) ? 0 : (nmcu_m - 1) / rint_m);
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic run(input bit s, input int n, input int r, input int md, input int lt);
    start_scan(s, n, r, md, lt);
    finish_scan();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", if1.cmd_valid, 0);
    chk("rst_ch", if1.cmd_ch, 0);
    chk("rst_dc", if1.cmd_dc_rst, 0);
    chk("rst_marker0", mk1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_err", err1, 0);
    chk("rst4_valid", if4.cmd_valid, 0);
    chk("rst4_busy", busy4, 0);
    rst = 1'b0;

    run(0, 2, 0, 0, 3);   // 4:4:4, two MCUs, fixed IDCT latency
    run(0, 3, 1, 0, 3);   // restart after every MCU
    run(0, 2, 0, 1, 1);   // random ready, completions coincide with handshakes
    run(0, 4, 2, 1, 2);   // random ready with restart intervals of two
    run(0, 0, 0, 0, 3);   // empty scan

    // Spurious completion while idle sets the sticky error.
    bd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    bd = 1'b0;
    err_m = 1;
    for (int k = 0; k < 3; k++) tick();

    // Reset mid-scan with two blocks outstanding.
    start_scan(0, 2, 0, 0, 20);
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("mid_rst_valid", if1.cmd_valid, 0);
    chk("mid_rst_ch", if1.cmd_ch, 0);
    chk("mid_rst_dc", if1.cmd_dc_rst, 0);
    chk("mid_rst_marker", mk1, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_err", err1, 0);
    rst = 1'b0;
    sb_q.delete();
    due_q.delete();
    scanning = 0; draining = 0; err_m = 0; mo = 0; prev_stall = 0; prev_fin = 0;
    run(0, 1, 0, 0, 3);

    run(1, 1, 0, 0, 3);   // four luma blocks per MCU

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mcu_sched.md
# mcu_sched

Block-command scheduler between the JPEG header/stream front end and the Huffman-decode → dequant → IDCT datapath. On `start` it walks the scan MCU by MCU and issues one command per 8x8 block with the channel index and a DC-predictor reset flag. It limits blocks in flight by counting IDCT block completions, drains the pipe at restart-interval boundaries, and pulses `done` once the last block has left the IDCT.

## Interface
Parameters:
- `CH`, 3, number of colour components; the channel field is `$clog2(CH+1)` bits wide, matching the IDCT channel tag.
- `BLOCKS_Y`, 1, blocks of channel 0 per MCU: 1 for 4:4:4, 2 for 4:2:2, 4 for 4:2:0. Channels 1..CH-1 issue one block each per MCU.
- `MAX_OUT`, 2, maximum number of commanded blocks not yet reported complete.
- `MCU_W`, 16, width of the MCU counters.

Ports:
- `clk`, in, 1, sole clock.
- `rst`, in, 1, synchronous, active-high.
- `start`, in, 1, single-cycle pulse that begins a scan; sampled only in IDLE.
- `num_mcus`, in, `MCU_W`, MCUs in the scan; sampled on the accepted `start`.
- `restart_int`, in, 16, MCUs per restart interval; 0 disables restarts; sampled on the accepted `start`.
- `cmd_valid`, out, 1, a block command is presented.
- `cmd_ready`, in, 1, the Huffman decoder accepts the command.
- `cmd_ch`, out, `$clog2(CH+1)`, channel of the commanded block.
- `cmd_dc_rst`, out, 1, the decoder clears the DC predictor of `cmd_ch` before decoding this block.
- `blk_done`, in, 1, one pulse per block leaving the IDCT (IDCT output valid).
- `rst_marker`, out, 1, single-cycle pulse telling the stream front end to consume an RSTn marker.
- `busy`, out, 1, high from the accepted `start` until `done`.
- `done`, out, 1, single-cycle pulse when the scan is complete.
- `err`, out, 1, sticky underflow flag; cleared only by `rst`.

## Operation
- Block order per MCU: `BLOCKS_Y` commands with ch=0, then ch=1 … ch=CH-1. Total blocks per scan = `num_mcus`*(BLOCKS_Y+CH-1).
- `cmd_dc_rst` = 1 on the first command of each channel in the scan, and on the first command of each channel after every restart boundary. It is 0 otherwise.
- Counters:
  - `blk_idx` runs 0..BLOCKS_Y+CH-2 and wraps to 0 at the end of each MCU.
  - `mcu_cnt` counts MCUs from 0 up to `num_mcus`.
  - `rint_cnt` counts MCUs within the current restart interval.
  - `out_cnt` runs 0..MAX_OUT: +1 on a handshake (`cmd_valid`&`cmd_ready`), -1 on `blk_done`, unchanged when both occur in the same cycle.
- FSM states:
  - IDLE: `start` → ISSUE, loads the config, clears the counters and sets `busy`. If `num_mcus`=0 it goes to FIN instead.
  - ISSUE: `cmd_valid` = (out_cnt<MAX_OUT). After a handshake on the last block of an MCU:
    - last MCU → FIN;
    - else if `restart_int`≠0 and `rint_cnt`+1 = `restart_int` → DRAIN;
    - else stay in ISSUE.
  - DRAIN: `cmd_valid`=0. When out_cnt=0 (including decrements this cycle), pulse `rst_marker` for one cycle, clear `rint_cnt`, arm `cmd_dc_rst` for every channel → ISSUE.
  - FIN: `cmd_valid`=0. When out_cnt=0, pulse `done` for one cycle, deassert `busy` → IDLE.
- No restart marker follows the last MCU, even when it falls on an interval boundary.
- `blk_done` while out_cnt=0: ignored, counter holds at 0, `err` set.
- `start` while busy: ignored.
- `rst` mid-scan: every state and counter returns to reset value on the next edge. Blocks already in flight are discarded by their own resets.

## Timing
- Reset values: `cmd_valid`=0, `cmd_ch`=0, `cmd_dc_rst`=0, `rst_marker`=0, `busy`=0, `done`=0, `err`=0. State is IDLE and all counters are 0.
- `cmd_valid` rises the cycle after the accepted `start`. `busy` rises on the same edge.
- Once `cmd_valid` is asserted, `cmd_ch` and `cmd_dc_rst` stay stable until the handshake, and `cmd_valid` does not drop before it.
- Back-to-back commands are allowed: with `cmd_ready` held high and out_cnt<MAX_OUT, one command is issued per cycle.
- `cmd_valid` is registered, so a `blk_done` that frees a slot enables a new command on the next cycle.
- `rst_marker` and `done` fire the cycle after out_cnt is seen reaching 0.
- Every output is registered; no output depends combinationally on an input.

## Test plan
- **4:4:4, MAX_OUT=2, 2 MCUs, restart_int=0, `cmd_ready`=1, `blk_done` 3 cycles after each handshake:**
  - channel sequence 0,1,2,0,1,2;
  - `cmd_dc_rst`=1 only on the first three commands;
  - out_cnt never exceeds 2;
  - one `done` pulse after the 6th `blk_done`.
- **BLOCKS_Y=4, CH=3, 1 MCU:** channel sequence 0,0,0,0,1,2 → 6 commands, `done` once.
- **num_mcus=3, restart_int=1:** `rst_marker` pulses twice, each while out_cnt=0 and before any command of the next MCU. `cmd_dc_rst`=1 on the first block of every channel in each MCU. No `rst_marker` after MCU 3.
- **`cmd_ready` toggled pseudo-randomly and `blk_done` coinciding with handshakes:** `cmd_ch`/`cmd_dc_rst` stable while stalled; out_cnt unchanged on coincident cycles; total of 6 handshakes for 2 MCUs at 4:4:4.
- **num_mcus=0:** no `cmd_valid`; `done` 2 cycles after `start`. A spurious `blk_done` in IDLE sets `err`=1, which stays 1 until `rst`.
- **`rst` asserted mid-scan with out_cnt=2, then a new `start`:** all outputs at reset values the cycle after `rst`; the next scan starts with `cmd_dc_rst`=1 for every channel.
